pq_order_monitor: RTL and testbench
===================================

PQ_ORDER_MONITOR -- requirements
Module: pq_order_monitor

Interface
REQ-001 Parameter KEY_W, default 16, width of the popped priority key.
REQ-002 Parameter CNT_W, default 8, width of the pop and violation counters.
REQ-003 Parameter DESCEND, default 0; 0 = min-first queue (keys non-decreasing), 1 = max-first queue (keys non-increasing).
REQ-004 Parameter ALLOW_EQ, default 1; 1 = equal consecutive keys legal, 0 = equal keys are a violation.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 clr  input  1  synchronous clear of results; returns to IDLE.
REQ-008 enb  input  1  monitor enable; pops ignored while low.
REQ-009 pop_valid  input  1  queue pop accepted this cycle.
REQ-010 pop_key  input  KEY_W  key of the popped element, valid with pop_valid.
REQ-011 empty  input  1  queue empty flag.
REQ-012 verdict  output  1  sticky: at least one order violation seen.
REQ-013 done  output  1  sticky: queue drained to empty after at least one checked pop.
REQ-014 pop_count  output  CNT_W  number of checked pops, saturating.
REQ-015 viol_count  output  CNT_W  number of violations, saturating.
REQ-016 first_bad_key  output  KEY_W  key of the first violating pop.
REQ-017 first_bad_idx  output  CNT_W  pop_count value at which the first violation occurred (0-based).
REQ-018 state  output  2  current FSM state encoding: IDLE=0, ARMED=1, TRACK=2, DONE=3.

Function
REQ-019 All outputs are registered; each output reflects inputs sampled on the previous rising edge (1-cycle latency).
REQ-020 A pop is "checked" when enb=1 and pop_valid=1 in state ARMED or TRACK.
REQ-021 IDLE: if enb=1, go to ARMED next cycle; pops in IDLE are ignored.
REQ-022 ARMED: first checked pop loads prev_key=pop_key, increments pop_count, performs no comparison, and moves to TRACK.
REQ-023 TRACK: each checked pop compares pop_key against prev_key, then loads prev_key=pop_key and increments pop_count.
REQ-024 Violation when DESCEND=0: pop_key < prev_key, or pop_key == prev_key with ALLOW_EQ=0.
REQ-025 Violation when DESCEND=1: pop_key > prev_key, or pop_key == prev_key with ALLOW_EQ=0.
REQ-026 Comparisons are unsigned over the full KEY_W bits.
REQ-027 On a violation, verdict is set and viol_count increments. On the first violation only, first_bad_key=pop_key and first_bad_idx=pop_count (pre-increment value).
REQ-028 TRACK with enb=1, empty=1 and pop_valid=0 goes to DONE and sets done=1.
REQ-029 pop_valid=1 and empty=1 in the same cycle: the pop is checked first; DONE is entered only on a later cycle with pop_valid=0.
REQ-030 ARMED with empty=1 stays in ARMED; done is not set without a checked pop.
REQ-031 DONE: all pops are ignored and counters and flags hold. A pop_valid=1 with enb=1 in DONE increments viol_count once (pop after drain) and sets verdict; the state stays DONE.
REQ-032 enb=0 in ARMED or TRACK freezes state, prev_key and all outputs.
REQ-033 Counters saturate at 2^CNT_W-1; no wrap-around. verdict and done remain sticky regardless of saturation.
REQ-034 clr=1: next cycle state=IDLE and all outputs are zero; clr takes priority over every event in the same cycle.

Reset
REQ-035 rst=1 at a clock edge forces state=IDLE and verdict=done=0, pop_count=viol_count=0, first_bad_key=first_bad_idx=0, prev_key=0.
REQ-036 rst takes priority over clr and all other inputs, including mid-sequence in TRACK or DONE.
REQ-037 No output changes asynchronously; reset is observed only at the clock edge.

Verification
REQ-038 DESCEND=0: enb=1, pop keys 3,5,5,9, then empty=1 -> verdict=0, pop_count=4, viol_count=0, done=1, state=DONE.
REQ-039 DESCEND=0, ALLOW_EQ=0: pop keys 10,12,7,7,20 -> viol_count=2, first_bad_key=7, first_bad_idx=2, verdict=1.
REQ-040 DESCEND=1: pop keys 16'hFFFF,16'h8000,16'h9000 -> verdict=1 one cycle after the 16'h9000 pop, first_bad_idx=2.
REQ-041 CNT_W=4: 20 ascending pops -> pop_count holds at 15; 18 violating pops -> viol_count=15, verdict=1.
REQ-042 pop_valid=1 with empty=1 on the last pop, then pop_valid=0 -> last pop counted, done asserts one cycle later. An extra pop in DONE -> viol_count+1.
REQ-043 rst pulse in TRACK after 3 pops, and clr=1 together with a violating pop -> all outputs 0, state=IDLE, no violation recorded.

Source files
------------

// File: rtl/pq_order_monitor.sv
// rtl/pq_order_monitor.sv - checks that keys popped from a priority queue come out in order
module pq_order_monitor #(
  parameter int KEY_W    = 16,
  parameter int CNT_W    = 8,
  parameter int DESCEND  = 0,
  parameter int ALLOW_EQ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enb,
  input  logic             pop_valid,
  input  logic [KEY_W-1:0] pop_key,
  input  logic             empty,
  output logic             verdict,
  output logic             done,
  output logic [CNT_W-1:0] pop_count,
  output logic [CNT_W-1:0] viol_count,
  output logic [KEY_W-1:0] first_bad_key,
  output logic [CNT_W-1:0] first_bad_idx,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           st;
  logic [KEY_W-1:0] prev_key;
  logic             is_bad;
  logic             pop_en;

  assign pop_en = enb && pop_valid;
  assign state  = st;

  always_comb begin
    is_bad = 1'b0;
    if (DESCEND != 0) is_bad = pop_key > prev_key;
    else              is_bad = pop_key < prev_key;
    if (ALLOW_EQ == 0 && pop_key == prev_key) is_bad = 1'b1;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st            <= IDLE;
      prev_key      <= '0;
      verdict       <= 1'b0;
      done          <= 1'b0;
      pop_count     <= '0;
      viol_count    <= '0;
      first_bad_key <= '0;
      first_bad_idx <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (enb) st <= ARMED;
        end
        ARMED: begin
          if (pop_en) begin
            prev_key  <= pop_key;
            pop_count <= sat_inc(pop_count);
            st        <= TRACK;
          end
        end
        TRACK: begin
          if (pop_en) begin
            if (is_bad) begin
              // verdict is still clear only until the first violation is captured
              if (!verdict) begin
                first_bad_key <= pop_key;
                first_bad_idx <= pop_count;
              end
              verdict    <= 1'b1;
              viol_count <= sat_inc(viol_count);
            end
            prev_key  <= pop_key;
            pop_count <= sat_inc(pop_count);
          end else if (enb && empty) begin
            done <= 1'b1;
            st   <= DONE;
          end
        end
        DONE: begin
          // a pop after the queue drained is itself an ordering fault
          if (pop_en) begin
            verdict    <= 1'b1;
            viol_count <= sat_inc(viol_count);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pq_order_monitor.sv
// tb/tb_pq_order_monitor.sv - scoreboard bench for pq_order_monitor over three parameter sets
module tb_pq_order_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, enb, pop_valid, empty;
  logic [15:0] pop_key;

  logic        v0, d0, v1, d1, v2, d2;
  logic [7:0]  pc0, vc0, fbi0, pc2, vc2, fbi2;
  logic [3:0]  pc1, vc1, fbi1;
  logic [15:0] fbk0, fbk1, fbk2;
  logic [1:0]  st0, st1, st2;

  pq_order_monitor #(.KEY_W(16), .CNT_W(8), .DESCEND(0), .ALLOW_EQ(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .enb(enb), .pop_valid(pop_valid), .pop_key(pop_key),
    .empty(empty), .verdict(v0), .done(d0), .pop_count(pc0), .viol_count(vc0),
    .first_bad_key(fbk0), .first_bad_idx(fbi0), .state(st0));

  pq_order_monitor #(.KEY_W(16), .CNT_W(4), .DESCEND(0), .ALLOW_EQ(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .enb(enb), .pop_valid(pop_valid), .pop_key(pop_key),
    .empty(empty), .verdict(v1), .done(d1), .pop_count(pc1), .viol_count(vc1),
    .first_bad_key(fbk1), .first_bad_idx(fbi1), .state(st1));

  pq_order_monitor #(.KEY_W(16), .CNT_W(8), .DESCEND(1), .ALLOW_EQ(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .enb(enb), .pop_valid(pop_valid), .pop_key(pop_key),
    .empty(empty), .verdict(v2), .done(d2), .pop_count(pc2), .viol_count(vc2),
    .first_bad_key(fbk2), .first_bad_idx(fbi2), .state(st2));

  typedef struct {
    int st; int v; int d; int pc; int vc; int fbk; int fbi;
  } obs_t;

  obs_t exp_q[3][$];
  int   tests = 0;
  int   fails = 0;

  int p_desc[3] = '{0, 0, 1};
  int p_aeq[3]  = '{1, 0, 1};
  int p_max[3]  = '{255, 15, 255};

  // reference model: phase 0 idle, 1 waiting for first pop, 2 tracking, 3 drained
  int m_ph[3], m_prev[3], m_v[3], m_d[3], m_pc[3], m_vc[3], m_fbk[3], m_fbi[3];
  bit m_seen[3];

  function automatic int sat(input int x, input int mx);
    return (x < mx) ? x + 1 : mx;
  endfunction

  task automatic model_step(input int k);
    obs_t o;
    bit   bad;
    int   key;
    key = int'(pop_key);
    if (rst || clr) begin
      m_ph[k] = 0; m_prev[k] = 0; m_v[k] = 0; m_d[k] = 0;
      m_pc[k] = 0; m_vc[k] = 0; m_fbk[k] = 0; m_fbi[k] = 0; m_seen[k] = 0;
    end else if (m_ph[k] == 0) begin
      if (enb) m_ph[k] = 1;
    end else if (m_ph[k] == 1) begin
      if (enb && pop_valid) begin
        m_prev[k] = key; m_pc[k] = sat(m_pc[k], p_max[k]); m_ph[k] = 2;
      end
    end else if (m_ph[k] == 2) begin
      if (enb && pop_valid) begin
        if (key == m_prev[k]) bad = (p_aeq[k] == 0);
        else if (p_desc[k] != 0) bad = key > m_prev[k];
        else bad = key < m_prev[k];
        if (bad) begin
          if (!m_seen[k]) begin
            m_seen[k] = 1; m_fbk[k] = key; m_fbi[k] = m_pc[k];
          end
          m_v[k] = 1; m_vc[k] = sat(m_vc[k], p_max[k]);
        end
        m_prev[k] = key; m_pc[k] = sat(m_pc[k], p_max[k]);
      end else if (enb && empty) begin
        m_ph[k] = 3; m_d[k] = 1;
      end
    end else begin
      if (enb && pop_valid) begin
        m_v[k] = 1; m_vc[k] = sat(m_vc[k], p_max[k]);
      end
    end
    o.st = m_ph[k]; o.v = m_v[k]; o.d = m_d[k]; o.pc = m_pc[k];
    o.vc = m_vc[k]; o.fbk = m_fbk[k]; o.fbi = m_fbi[k];
    exp_q[k].push_back(o);
  endtask

  task automatic drive(input bit r, input bit c, input bit e, input bit pv,
                       input int key, input bit em);
    @(negedge clk);
    rst = r; clr = c; enb = e; pop_valid = pv; pop_key = key[15:0]; empty = em;
    for (int k = 0; k < 3; k++) model_step(k);
  endtask

  task automatic pop(input int key);
    drive(0, 0, 1, 1, key, 0);
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s u%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() > 0) begin
        obs_t e, a;
        e = exp_q[k].pop_front();
        case (k)
          0: begin a.st = int'(st0); a.v = int'(v0); a.d = int'(d0); a.pc = int'(pc0);
                   a.vc = int'(vc0); a.fbk = int'(fbk0); a.fbi = int'(fbi0); end
          1: begin a.st = int'(st1); a.v = int'(v1); a.d = int'(d1); a.pc = int'(pc1);
                   a.vc = int'(vc1); a.fbk = int'(fbk1); a.fbi = int'(fbi1); end
          default: begin a.st = int'(st2); a.v = int'(v2); a.d = int'(d2); a.pc = int'(pc2);
                   a.vc = int'(vc2); a.fbk = int'(fbk2); a.fbi = int'(fbi2); end
        endcase
        chk("state", k, a.st, e.st);
        chk("verdict", k, a.v, e.v);
        chk("done", k, a.d, e.d);
        chk("pop_count", k, a.pc, e.pc);
        chk("viol_count", k, a.vc, e.vc);
        chk("first_bad_key", k, a.fbk, e.fbk);
        chk("first_bad_idx", k, a.fbi, e.fbi);
      end
    end
  end

  initial begin
    rst = 1; clr = 0; enb = 0; pop_valid = 0; pop_key = '0; empty = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 77, 1);

    // ordered drain with an equal pair, then a pop after drain
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 1);
    pop(3); pop(5); pop(5); pop(9);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 4, 1);
    drive(0, 0, 0, 1, 4, 1);

    drive(0, 1, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    pop(10); pop(12); pop(7); pop(7); pop(20);

    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    pop(16'hFFFF); pop(16'h8000); pop(16'h9000);
    drive(0, 0, 0, 1, 16'h0001, 0);
    pop(16'h0000);

    // saturation of both counters
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) pop(100 + i);
    for (int i = 0; i < 18; i++) pop(90 - i);

    // last pop coincides with empty
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    pop(1); pop(2);
    drive(0, 0, 1, 1, 3, 1);
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 9, 1);
    drive(0, 0, 1, 0, 0, 1);

    // reset mid-track, and clear racing a violating pop
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    pop(5); pop(6); pop(7);
    drive(1, 1, 1, 1, 2, 0);
    drive(0, 0, 1, 0, 0, 0);
    pop(50); pop(60);
    drive(0, 1, 1, 1, 10, 0);
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      int r, c, key;
      r = ($urandom_range(0, 99) == 0) ? 1 : 0;
      c = ($urandom_range(0, 59) == 0) ? 1 : 0;
      key = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                        : int'($urandom_range(0, 15));
      drive(r[0], c[0], ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
            key, ($urandom_range(0, 7) == 0));
    end

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    for (int k = 0; k < 3; k++) chk("queue_drained", k, exp_q[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
